// File: rtl/key_expand_128.sv
// key_expand_128: iterative AES-128 key schedule, one round key every 5 cycles,
// using an external zero-latency S-box that is fed one SubWord byte per cycle.
module key_expand_128 (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] key_in,
  output logic [7:0]   sbox_addr,
  input  logic [7:0]   sbox_data,
  output logic [127:0] round_key,
  output logic [3:0]   rk_index,
  output logic         rk_valid,
  output logic         busy,
  output logic         done
);
  typedef enum logic [1:0] {IDLE, SUB, UPDATE} state_t;
  state_t       r_state, w_next;
  logic [1:0]   r_j;
  logic [7:0]   r_rcon;
  logic [31:0]  r_temp;
  logic [31:0]  w_rot, w_t, w_w0, w_w1, w_w2, w_w3;
  logic         w_start;
  // busy stays high through the done cycle, so a start there is ignored
  assign busy    = (r_state != IDLE) || done;
  assign w_start = start && (r_state == IDLE) && !done;
  always_comb begin
    w_rot     = {round_key[23:0], round_key[31:24]};
    sbox_addr = r_state != SUB ? 8'h00 :
                r_j == 2'd0    ? w_rot[31:24] :
                r_j == 2'd1    ? w_rot[23:16] :
                r_j == 2'd2    ? w_rot[15:8]  : w_rot[7:0];
    w_t       = {r_temp[31:24] ^ r_rcon, r_temp[23:0]};
    w_w0      = round_key[127:96] ^ w_t;
    w_w1      = round_key[95:64] ^ w_w0;
    w_w2      = round_key[63:32] ^ w_w1;
    w_w3      = round_key[31:0] ^ w_w2;
    w_next    = r_state == IDLE ? (w_start ? SUB : IDLE) :
                r_state == SUB  ? (r_j == 2'd3 ? UPDATE : SUB) :
                (rk_index == 4'd9 ? IDLE : SUB);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_j       <= 2'd0;
      r_rcon    <= 8'h01;
      r_temp    <= 32'h0;
      round_key <= 128'h0;
      rk_index  <= 4'd0;
      rk_valid  <= 1'b0;
      done      <= 1'b0;
    end else begin
      r_state  <= w_next;
      rk_valid <= 1'b0;
      done     <= 1'b0;
      if (w_start) begin
        round_key <= key_in;
        rk_index  <= 4'd0;
        rk_valid  <= 1'b1;
        r_rcon    <= 8'h01;
        r_j       <= 2'd0;
      end
      if (r_state == SUB) begin
        r_temp <= {r_temp[23:0], sbox_data};
        r_j    <= r_j + 2'd1;
      end
      if (r_state == UPDATE) begin
        round_key <= {w_w0, w_w1, w_w2, w_w3};
        rk_index  <= rk_index + 4'd1;
        rk_valid  <= 1'b1;
        r_rcon    <= {r_rcon[6:0], 1'b0} ^ (r_rcon[7] ? 8'h1b : 8'h00);
        done      <= rk_index == 4'd9;
      end
    end
  end
endmodule

// File: tb/tb_key_expand_128.sv
// tb_key_expand_128: scoreboard bench for key_expand_128 with a behavioural AES S-box.
module tb_key_expand_128;
  logic         clk = 1'b0;
  logic         rst, start;
  logic [127:0] key_in;
  logic [7:0]   sbox_addr, sbox_data;
  logic [127:0] round_key;
  logic [3:0]   rk_index;
  logic         rk_valid, busy, done;

  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] FIPS_K1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] FIPS_K10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] ZERO_K1  = 128'h62636363626363636263636362636363;
  localparam logic [127:0] ZERO_K10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [2047:0] t;
    t = SBOX;
    return t[2047 - 8 * int'(a) -: 8];
  endfunction

  assign sbox_data = sbox(sbox_addr);

  key_expand_128 dut (
    .clk(clk), .rst(rst), .start(start), .key_in(key_in),
    .sbox_addr(sbox_addr), .sbox_data(sbox_data), .round_key(round_key),
    .rk_index(rk_index), .rk_valid(rk_valid), .busy(busy), .done(done));

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]   idx;
    logic [127:0] key;
    logic         done;
  } exp_t;
  exp_t q[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected round keys for the first n rounds; spec vectors pin idx1/idx10 when known.
  task automatic push_exp(input logic [127:0] k, input int n, input bit known,
                          input logic [127:0] k1, input logic [127:0] k10);
    logic [31:0] w[4];
    logic [31:0] t;
    logic [7:0]  rc;
    exp_t        e;
    w[0] = k[127:96]; w[1] = k[95:64]; w[2] = k[63:32]; w[3] = k[31:0];
    rc = 8'h01;
    for (int r = 0; r < n && r <= 10; r++) begin
      if (r > 0) begin
        t = {sbox(w[3][23:16]) ^ rc, sbox(w[3][15:8]), sbox(w[3][7:0]), sbox(w[3][31:24])};
        w[0] = w[0] ^ t;
        w[1] = w[1] ^ w[0];
        w[2] = w[2] ^ w[1];
        w[3] = w[3] ^ w[2];
        rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
      end
      e.idx  = 4'(r);
      e.key  = {w[0], w[1], w[2], w[3]};
      if (known && r == 1) e.key = k1;
      if (known && r == 10) e.key = k10;
      e.done = (r == 10);
      q.push_back(e);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rk_valid === 1'b1) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rk: got idx %0d key %h, expected no strobe", rk_index, round_key);
      end else begin
        e = q.pop_front();
        chk("rk_key", round_key, e.key);
        chk("rk_index", 128'(rk_index), 128'(e.idx));
        chk("rk_done", 128'(done), 128'(e.done));
      end
    end else if (rst === 1'b0) begin
      chk("done_without_valid", 128'(done), 128'(0));
    end
  end

  // Entered at a negedge; returns at the negedge of cycle T+52 with start low.
  task automatic expand(input logic [127:0] k, input bit disturb, input logic [39:0] addrs);
    key_in = k;
    start  = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    key_in = ~k;
    for (int c = 1; c <= 52; c++) begin
      @(negedge clk);
      chk("rk_valid_timing", 128'(rk_valid), 128'(c <= 51 && (c - 1) % 5 == 0));
      chk("busy_timing", 128'(busy), 128'(c <= 51));
      chk("done_timing", 128'(done), 128'(c == 51));
      if (c <= 5) chk("sbox_addr", 128'(sbox_addr), 128'(addrs[8 * (5 - c) +: 8]));
      start = disturb && (c == 7 || c == 51);
    end
  endtask

  task automatic check_idle_zero(input string tag);
    chk({tag, "_round_key"}, round_key, 128'h0);
    chk({tag, "_rk_index"}, 128'(rk_index), 128'h0);
    chk({tag, "_rk_valid"}, 128'(rk_valid), 128'h0);
    chk({tag, "_busy"}, 128'(busy), 128'h0);
    chk({tag, "_done"}, 128'(done), 128'h0);
    chk({tag, "_sbox_addr"}, 128'(sbox_addr), 128'h0);
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    key_in = '0;
    repeat (2) @(negedge clk);
    check_idle_zero("reset");
    rst = 1'b0;
    @(negedge clk);
    push_exp(FIPS_KEY, 11, 1'b1, FIPS_K1, FIPS_K10);
    expand(FIPS_KEY, 1'b0, 40'hcf4f3c0900);
    chk("hold_key_after_done", round_key, FIPS_K10);
    chk("hold_idx_after_done", 128'(rk_index), 128'd10);
    push_exp('0, 11, 1'b1, ZERO_K1, ZERO_K10);
    expand('0, 1'b0, 40'h0);
    push_exp(FIPS_KEY, 11, 1'b1, FIPS_K1, FIPS_K10);
    expand(FIPS_KEY, 1'b1, 40'hcf4f3c0900);
    push_exp(FIPS_KEY, 4, 1'b0, '0, '0);
    key_in = FIPS_KEY;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (20) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_idle_zero("midrun_reset");
    chk("queue_after_reset", 128'(q.size()), 128'h0);
    rst = 1'b0;
    @(negedge clk);
    push_exp(FIPS_KEY, 11, 1'b1, FIPS_K1, FIPS_K10);
    expand(FIPS_KEY, 1'b0, 40'hcf4f3c0900);
    push_exp('0, 11, 1'b1, ZERO_K1, ZERO_K10);
    expand('0, 1'b0, 40'h0);
    repeat (3) @(negedge clk);
    chk("queue_empty", 128'(q.size()), 128'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
